fma16_arbiter: RTL

Two-requester scheduler for the shared combinational fma16 datapath. Arbitrates round-robin between requesters, registers the winning operands into an issue stage that drives the datapath, and captures `fma_result` one cycle later into a per-requester 2-entry response FIFO with valid/ready handshake. Sits between the requesting units and the single fma16 instance; one operation issued per cycle total.

---
 rtl/fma16_arb_pkg.sv | 33 +++
 rtl/fma16_arbiter_if.sv | 41 ++++
 rtl/fma16_resp_fifo.sv | 56 +++++
 rtl/fma16_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fma16_arb_pkg.sv
// fma16_arb_pkg: shared types and constants for the fma16 two-requester scheduler.
// Used by fma16_arbiter_if, fma16_resp_fifo and fma16_arbiter.
package fma16_arb_pkg;

    localparam int FMA16_NREQ       = 2;
    localparam int FMA16_RESP_DEPTH = 2;

    // A requester may hold at most this many ops in flight plus buffered responses.
    localparam logic [1:0] FMA16_CNT_MAX = 2'd2;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic        mul;
        logic        add;
    } fma16_op_t;

    // Round-robin pick between two candidates; on a tie the requester that
    // did not win last time is taken.
    function automatic logic [1:0] rr_pick(input logic [1:0] cand, input logic last);
        logic [1:0] g;
        g = 2'b00;
        case (cand)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = last ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fma16_arbiter_if.sv
// fma16_arbiter_if: request, datapath and response signals of the fma16 scheduler.
// slave  = the scheduler itself, master = requesters plus the fma16 datapath.
interface fma16_arbiter_if;
    import fma16_arb_pkg::*;

    logic [FMA16_NREQ-1:0]        req_valid;
    logic [FMA16_NREQ-1:0]        req_ready;
    logic [FMA16_NREQ-1:0][15:0]  req_x;
    logic [FMA16_NREQ-1:0][15:0]  req_y;
    logic [FMA16_NREQ-1:0][15:0]  req_z;
    logic [FMA16_NREQ-1:0]        req_mul;
    logic [FMA16_NREQ-1:0]        req_add;

    logic [15:0]                  fma_x;
    logic [15:0]                  fma_y;
    logic [15:0]                  fma_z;
    logic                         fma_mul;
    logic                         fma_add;
    logic [15:0]                  fma_result;

    logic [FMA16_NREQ-1:0]        resp_valid;
    logic [FMA16_NREQ-1:0]        resp_ready;
    logic [FMA16_NREQ-1:0][15:0]  resp_data;

    logic [FMA16_NREQ-1:0][15:0]  stat_ops;

    modport slave (
        input  req_valid, req_x, req_y, req_z, req_mul, req_add,
        input  fma_result, resp_ready,
        output req_ready, fma_x, fma_y, fma_z, fma_mul, fma_add,
        output resp_valid, resp_data, stat_ops
    );

    modport master (
        output req_valid, req_x, req_y, req_z, req_mul, req_add,
        output fma_result, resp_ready,
        input  req_ready, fma_x, fma_y, fma_z, fma_mul, fma_add,
        input  resp_valid, resp_data, stat_ops
    );

endinterface

// File: rtl/fma16_resp_fifo.sv
// fma16_resp_fifo: 2-entry response buffer for one requester.
// Push and pop in the same cycle are allowed, also when full.
module fma16_resp_fifo
    import fma16_arb_pkg::*;
#(
    parameter int DEPTH = FMA16_RESP_DEPTH,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_valid   = (r_count != 2'd0);
    assign o_full    = (r_count == 2'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & o_valid;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fma16_arbiter.sv
// fma16_arbiter: round-robin scheduler in front of the shared combinational fma16.
// Winning operands go to a one-deep issue register that drives the datapath; the
// result is captured into the owner's response FIFO on the following edge.
// Each requester holds a credit count (in flight + buffered) capped at 2, which
// guarantees its response FIFO never overflows.
// Optional build macro: FMA16_ARB_STATS_EN adds per-requester 16-bit accept
// counters on stat_ops; without it stat_ops is tied to zero.
module fma16_arbiter
    import fma16_arb_pkg::*;
#(
    parameter int NREQ       = FMA16_NREQ,
    parameter int RESP_DEPTH = FMA16_RESP_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    fma16_arbiter_if.slave bus
);

    logic [NREQ-1:0]       w_drain;
    logic [NREQ-1:0]       w_elig;
    logic [NREQ-1:0]       w_cand;
    logic [NREQ-1:0]       w_grant;
    logic [NREQ-1:0]       w_accept;
    logic [NREQ-1:0]       w_push;
    logic [NREQ-1:0]       w_resp_valid;
    logic [NREQ-1:0]       w_fifo_full;
    logic [NREQ-1:0][15:0] w_resp_data;
    logic                  w_sel;
    fma16_op_t             w_req_op;
    logic                  w_unused_full;

    logic [1:0]            r_cnt [NREQ];
    logic                  r_last;
    fma16_op_t             r_iss_op;
    logic                  r_iss_valid;
    logic                  r_iss_tag;

    // Eligibility and grant; a draining response frees a credit in the same cycle.
    always_comb begin
        w_drain = w_resp_valid & bus.resp_ready;
        w_elig  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = (r_cnt[i] < FMA16_CNT_MAX) | w_drain[i];
        end
        w_cand   = bus.req_valid & w_elig;
        w_grant  = reset ? '0 : rr_pick(w_cand, r_last);
        w_accept = bus.req_valid & w_grant;
        w_sel    = w_grant[1];
    end

    // Operand mux for the winning requester.
    always_comb begin
        w_req_op.x   = bus.req_x[w_sel];
        w_req_op.y   = bus.req_y[w_sel];
        w_req_op.z   = bus.req_z[w_sel];
        w_req_op.mul = bus.req_mul[w_sel];
        w_req_op.add = bus.req_add[w_sel];
    end

    assign bus.req_ready = w_grant;

    // Issue register; operands hold their last value when nothing is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss_valid <= 1'b0;
            r_iss_tag   <= 1'b0;
            r_iss_op    <= '0;
        end else begin
            r_iss_valid <= |w_accept;
            if (|w_accept) begin
                r_iss_op  <= w_req_op;
                r_iss_tag <= w_sel;
            end
        end
    end

    // Round-robin pointer, moved only by a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (|w_grant) begin
            r_last <= w_sel;
        end
    end

    // Credit counters: +1 on accept, -1 on drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({w_accept[i], w_drain[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 2'd1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 2'd1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    assign bus.fma_x   = r_iss_op.x;
    assign bus.fma_y   = r_iss_op.y;
    assign bus.fma_z   = r_iss_op.z;
    assign bus.fma_mul = r_iss_op.mul;
    assign bus.fma_add = r_iss_op.add;

    assign w_push[0] = r_iss_valid & (r_iss_tag == 1'b0);
    assign w_push[1] = r_iss_valid & (r_iss_tag == 1'b1);

    fma16_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(16)) u_fifo0 (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push[0]),
        .i_data  (bus.fma_result),
        .i_pop   (bus.resp_ready[0]),
        .o_valid (w_resp_valid[0]),
        .o_full  (w_fifo_full[0]),
        .o_data  (w_resp_data[0])
    );

    fma16_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(16)) u_fifo1 (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push[1]),
        .i_data  (bus.fma_result),
        .i_pop   (bus.resp_ready[1]),
        .o_valid (w_resp_valid[1]),
        .o_full  (w_fifo_full[1]),
        .o_data  (w_resp_data[1])
    );

    // Full flags are implied by the credit count and need no further use here.
    assign w_unused_full = &w_fifo_full;

    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_data  = w_resp_data;

`ifdef FMA16_ARB_STATS_EN
    logic [NREQ-1:0][15:0] r_stat;

    // Accept counters, free-running with 16-bit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_accept[i]) begin
                    r_stat[i] <= r_stat[i] + 16'd1;
                end
            end
        end
    end

    assign bus.stat_ops = r_stat;
`else
    assign bus.stat_ops = '0;
`endif

endmodule
